// File: rtl/ingress_pkt_framer.sv
// Per-port ingress store-and-forward framer: buffers raw beats, forwards only complete packets.
// Optional build macro INGRESS_DROP_CNT_EN adds a saturating drop_cnt output.
module ingress_pkt_framer #(
    parameter int  PORT_NUM       = 0,
    parameter int  PORT_NUB_TOTAL = 16,
    parameter int  DATA_WIDTH     = 32,
    parameter int  FIFO_DEPTH     = 64,
    parameter int  MAX_PKT_LEN    = 32,
    localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_sop,
    input  logic                  wr_eop,
    input  logic                  wr_vld,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [WIDTH_SEL-1:0]  rx,
    output logic [WIDTH_SEL-1:0]  tx,
    output logic                  vld,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  ready_in,
`ifdef INGRESS_DROP_CNT_EN
    output logic [15:0]           drop_cnt,
`endif
    output logic                  error,
    output logic                  full
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int LEN_W   = $clog2(MAX_PKT_LEN + 1);
    localparam int ENTRY_W = WIDTH_SEL + 1 + DATA_WIDTH;

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] DEPTH_P   = PTR_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] MAXLEN_P  = PTR_W'(MAX_PKT_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAXLEN_L  = LEN_W'(MAX_PKT_LEN);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t                 state, state_nxt;
    logic [PTR_W-1:0]       wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]       cmt_ptr, cmt_ptr_nxt;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LEN_W-1:0]       len, len_nxt;
    logic [WIDTH_SEL-1:0]   tx_hdr, tx_hdr_nxt;
    logic                   err_nxt;

    logic                   wr_en;
    logic [PTR_W-1:0]       wr_addr;
    logic [ENTRY_W-1:0]     wr_entry;

    logic                   is_hdr;
    logic                   store;
    logic [PTR_W-1:0]       base;
    logic [LEN_W-1:0]       blen;
    logic [PTR_W-1:0]       used_b;
    logic                   ovf;
    logic [WIDTH_SEL-1:0]   beat_tx;

    logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];

    logic [PTR_W-1:0]       used;
    logic [PTR_W-1:0]       free_beats;
    logic                   rd_load;

    assign rx = WIDTH_SEL'(PORT_NUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            cmt_ptr <= '0;
            len     <= '0;
            tx_hdr  <= '0;
            error   <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_ptr  <= wr_ptr_nxt;
            cmt_ptr <= cmt_ptr_nxt;
            len     <= len_nxt;
            tx_hdr  <= tx_hdr_nxt;
            error   <= err_nxt;
        end
    end

    // A header arriving in any state is placed at cmt_ptr: in IDLE/DROP wr_ptr already
    // equals cmt_ptr, and in RECV it is the abort-and-restart rewind target.
    always_comb begin
        state_nxt   = state;
        wr_ptr_nxt  = wr_ptr;
        cmt_ptr_nxt = cmt_ptr;
        len_nxt     = len;
        tx_hdr_nxt  = tx_hdr;
        err_nxt     = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr;
        wr_entry    = '0;
        is_hdr      = 1'b0;
        store       = 1'b0;
        base        = wr_ptr;
        blen        = len;
        beat_tx     = tx_hdr;

        if (wr_vld) begin
            case (state)
                IDLE: begin
                    if (wr_sop) is_hdr = 1'b1;
                    else        err_nxt = 1'b1;
                end
                RECV: begin
                    if (wr_sop) begin
                        is_hdr     = 1'b1;
                        err_nxt    = 1'b1;
                        wr_ptr_nxt = cmt_ptr;
                    end else begin
                        store = 1'b1;
                    end
                end
                DROP: begin
                    if (wr_sop)      is_hdr    = 1'b1;
                    else if (wr_eop) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (is_hdr) begin
            store   = 1'b1;
            base    = cmt_ptr;
            blen    = '0;
            beat_tx = wr_data[WIDTH_SEL-1:0];
        end

        used_b = base - rd_ptr;
        ovf    = (blen == MAXLEN_L) || (used_b == DEPTH_P);

        if (store) begin
            if (ovf) begin
                // An overflowing eop beat already ends the packet, so there is nothing left to drop.
                wr_ptr_nxt = cmt_ptr;
                err_nxt    = 1'b1;
                len_nxt    = '0;
                state_nxt  = wr_eop ? IDLE : DROP;
            end else begin
                wr_en      = 1'b1;
                wr_addr    = base;
                wr_entry   = {beat_tx, wr_eop, wr_data};
                wr_ptr_nxt = base + PTR_ONE;
                len_nxt    = blen + LEN_ONE;
                if (is_hdr) tx_hdr_nxt = beat_tx;
                if (wr_eop) begin
                    cmt_ptr_nxt = base + PTR_ONE;
                    state_nxt   = IDLE;
                end else begin
                    state_nxt   = RECV;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr[AW-1:0]] <= wr_entry;
    end

    assign rd_load = (rd_ptr != cmt_ptr) && (!vld || ready_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            vld    <= 1'b0;
            last   <= 1'b0;
            data   <= '0;
            tx     <= '0;
        end else if (rd_load) begin
            {tx, last, data} <= mem[rd_ptr[AW-1:0]];
            vld              <= 1'b1;
            rd_ptr           <= rd_ptr + PTR_ONE;
        end else if (ready_in) begin
            vld <= 1'b0;
        end
    end

    assign used       = wr_ptr - rd_ptr;
    assign free_beats = DEPTH_P - used;
    assign full       = (free_beats < MAXLEN_P);

`ifdef INGRESS_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)                               drop_cnt <= '0;
        else if (err_nxt && drop_cnt != '1)    drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_ingress_pkt_framer.sv
// Directed self-checking bench for ingress_pkt_framer (default and INGRESS_DROP_CNT_EN builds).
module tb_ingress_pkt_framer;

    localparam int PORT_NUM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_sop, wr_eop, wr_vld;
    logic [31:0] wr_data;
    logic [3:0]  rx, tx;
    logic        vld, last, error, full, ready_in;
    logic [31:0] data;
`ifdef INGRESS_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int n_checks   = 0;
    int n_pass     = 0;
    int vld_cycles = 0;
    int err_cycles = 0;

    always #5 clk = ~clk;

    ingress_pkt_framer #(
        .PORT_NUM       (PORT_NUM),
        .PORT_NUB_TOTAL (16),
        .DATA_WIDTH     (32),
        .FIFO_DEPTH     (64),
        .MAX_PKT_LEN    (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_sop   (wr_sop),
        .wr_eop   (wr_eop),
        .wr_vld   (wr_vld),
        .wr_data  (wr_data),
        .rx       (rx),
        .tx       (tx),
        .vld      (vld),
        .last     (last),
        .data     (data),
        .ready_in (ready_in),
`ifdef INGRESS_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .error    (error),
        .full     (full)
    );

    always @(negedge clk) begin
        if (vld)   vld_cycles++;
        if (error) err_cycles++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [31:0] d);
        wr_sop  = sop;
        wr_eop  = eop;
        wr_data = d;
        wr_vld  = 1'b1;
        step();
        wr_sop  = 1'b0;
        wr_eop  = 1'b0;
        wr_vld  = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [3:0] etx, input logic elast,
                               input logic [31:0] ed);
        check({tag, "_vld"},  vld,  1'b1);
        check({tag, "_tx"},   tx,   etx);
        check({tag, "_last"}, last, elast);
        check({tag, "_data"}, data, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, e0;
        rst = 1'b1; wr_sop = 1'b0; wr_eop = 1'b0; wr_vld = 1'b0; wr_data = '0; ready_in = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_vld",   vld,   1'b0);
        check("rst_last",  last,  1'b0);
        check("rst_data",  data,  32'h0);
        check("rst_tx",    tx,    4'h0);
        check("rst_error", error, 1'b0);
        check("rst_full",  full,  1'b0);
        check("rst_rx",    rx,    4'(PORT_NUM));
`ifdef INGRESS_DROP_CNT_EN
        check("rst_drop_cnt", drop_cnt, 16'h0);
`endif

        // 3-beat packet to port 5
        beat(1'b1, 1'b0, 32'hA000_0005);
        beat(1'b0, 1'b0, 32'h1111_1111);
        beat(1'b0, 1'b1, 32'h2222_2222);
        check("t1_vld_n1", vld, 1'b0);
        step(); expect_beat("t1_b0", 4'd5, 1'b0, 32'hA000_0005);
        check("t1_rx", rx, 4'(PORT_NUM));
        step(); expect_beat("t1_b1", 4'd5, 1'b0, 32'h1111_1111);
        step(); expect_beat("t1_b2", 4'd5, 1'b1, 32'h2222_2222);
        step(); check("t1_end_vld", vld, 1'b0);

        // single-beat packet to port 2
        beat(1'b1, 1'b1, 32'hC0DE_0002);
        check("t2_err", error, 1'b0);
        step(); expect_beat("t2_b0", 4'd2, 1'b1, 32'hC0DE_0002);
        check("t2_err2", error, 1'b0);
        step(); check("t2_end_vld", vld, 1'b0);

        // oversize packet (33 beats) then a good one
        v0 = vld_cycles;
        beat(1'b1, 1'b0, 32'h0000_0007);
        for (int i = 1; i < 32; i++) beat(1'b0, 1'b0, 32'(i));
        check("t3_err_b32", error, 1'b0);
        beat(1'b0, 1'b1, 32'h0000_0020);
        check("t3_err_b33", error, 1'b1);
        step(); check("t3_err_pulse", error, 1'b0);
        repeat (3) step();
        check("t3_no_vld", vld_cycles - v0, 0);
        beat(1'b1, 1'b0, 32'h0000_0013);
        beat(1'b0, 1'b1, 32'hBEEF_0001);
        step(); expect_beat("t3_g0", 4'd3, 1'b0, 32'h0000_0013);
        step(); expect_beat("t3_g1", 4'd3, 1'b1, 32'hBEEF_0001);
        step(); check("t3_end_vld", vld, 1'b0);

        // sop mid-packet aborts the first packet
        v0 = vld_cycles; e0 = err_cycles;
        beat(1'b1, 1'b0, 32'h0000_0009);
        beat(1'b0, 1'b0, 32'h5555_5555);
        beat(1'b1, 1'b0, 32'h0000_0004);
        check("t4_abort_err", error, 1'b1);
        beat(1'b0, 1'b0, 32'h6666_6666);
        beat(1'b0, 1'b1, 32'h7777_7777);
        check("t4_vld_n1", vld, 1'b0);
        step(); expect_beat("t4_b0", 4'd4, 1'b0, 32'h0000_0004);
        step(); expect_beat("t4_b1", 4'd4, 1'b0, 32'h6666_6666);
        step(); expect_beat("t4_b2", 4'd4, 1'b1, 32'h7777_7777);
        step(); check("t4_end_vld", vld, 1'b0);
        check("t4_err_count", err_cycles - e0, 1);
        check("t4_vld_count", vld_cycles - v0, 3);

        // backpressure with two committed packets
        ready_in = 1'b0;
        beat(1'b1, 1'b0, 32'h0000_00A1);
        beat(1'b0, 1'b1, 32'h0000_00A2);
        beat(1'b1, 1'b0, 32'h0000_00B6);
        beat(1'b0, 1'b0, 32'h0000_00B2);
        beat(1'b0, 1'b1, 32'h0000_00B3);
        step(); expect_beat("t5_hold0", 4'd1, 1'b0, 32'h0000_00A1);
        repeat (3) step();
        expect_beat("t5_hold1", 4'd1, 1'b0, 32'h0000_00A1);
        ready_in = 1'b1;
        step(); expect_beat("t5_a2", 4'd1, 1'b1, 32'h0000_00A2);
        step(); expect_beat("t5_b0", 4'd6, 1'b0, 32'h0000_00B6);
        step(); expect_beat("t5_b1", 4'd6, 1'b0, 32'h0000_00B2);
        step(); expect_beat("t5_b2", 4'd6, 1'b1, 32'h0000_00B3);
        step(); check("t5_end_vld", vld, 1'b0);

        // fill: 16 + 16 + 4 beats with the output stalled
        ready_in = 1'b0;
        beat(1'b1, 1'b0, 32'h1000_0008);
        for (int i = 1; i < 16; i++) beat(1'b0, i == 15, 32'h1000_0000 + 32'(i));
        beat(1'b1, 1'b0, 32'h2000_000A);
        for (int i = 1; i < 16; i++) beat(1'b0, i == 15, 32'h2000_0000 + 32'(i));
        repeat (2) step();
        check("t6_full_31", full, 1'b0);
        beat(1'b1, 1'b0, 32'h3000_000C);
        for (int i = 1; i < 4; i++) beat(1'b0, i == 3, 32'h3000_0000 + 32'(i));
        repeat (2) step();
        check("t6_full_35", full, 1'b1);
        expect_beat("t6_p1hdr", 4'd8, 1'b0, 32'h1000_0008);
        ready_in = 1'b1;
        repeat (16) step();
        ready_in = 1'b0;
        expect_beat("t6_p2hdr", 4'd10, 1'b0, 32'h2000_000A);
        check("t6_full_drain", full, 1'b0);

        // reset with stored packets and a partial packet in flight
        beat(1'b1, 1'b0, 32'h0000_0001);
        beat(1'b0, 1'b0, 32'hDEAD_0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t7_vld",  vld,  1'b0);
        check("t7_data", data, 32'h0);
        check("t7_tx",   tx,   4'h0);
        check("t7_full", full, 1'b0);
`ifdef INGRESS_DROP_CNT_EN
        check("t7_drop_cnt", drop_cnt, 16'h0);
`endif
        v0 = vld_cycles;
        ready_in = 1'b1;
        repeat (6) step();
        check("t7_no_vld", vld_cycles - v0, 0);

        // three stray non-sop beats in IDLE
        v0 = vld_cycles; e0 = err_cycles;
        beat(1'b0, 1'b0, 32'h0000_0111);
        beat(1'b0, 1'b1, 32'h0000_0222);
        beat(1'b0, 1'b0, 32'h0000_0333);
        repeat (2) step();
        check("t8_err_count", err_cycles - e0, 3);
        check("t8_no_vld", vld_cycles - v0, 0);
`ifdef INGRESS_DROP_CNT_EN
        check("t8_drop_cnt", drop_cnt, 16'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
